// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: FSM encoding, cause codes
// and the default return offset.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StExcFlush = 2'd1,
        StRetFlush = 2'd2,
        StDrain    = 2'd3
    } exc_state_e;

    localparam logic [31:0] CAUSE_UNDEF        = 32'd0;
    localparam logic [31:0] CAUSE_OVF          = 32'd1;
    localparam logic [31:0] RET_OFFSET_DEFAULT = 32'd2;

endpackage

// File: rtl/register32bit_normal.sv
// 32-bit register with write enable and asynchronous active-high clear.
module register32bit_normal (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= 32'd0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/return controller: captures EPC/Cause, flushes the pipeline,
// redirects fetch and holds the pipeline for a fixed drain period.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter logic [31:0] RET_OFFSET   = RET_OFFSET_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        idex_epc_write,
    input  logic        idex_cause_write,
    input  logic        ex_overflow,
    input  logic [31:0] idex_PCVal,
    input  logic        eret_ex,
    output logic [31:0] EPC,
    output logic [31:0] Cause,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        pipe_hold,
    output logic        exc_busy
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    exc_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic        idle;
    logic        exc_event;
    logic        eret_event;
    logic        cause_we;
    logic [31:0] cause_d;

    assign idle       = (state_q == StIdle);
    assign exc_event  = idle && (idex_epc_write || ex_overflow);
    assign eret_event = idle && eret_ex && !exc_event;
    assign cause_we   = exc_event && (idex_cause_write || ex_overflow);
    // Undefined instruction takes priority over a simultaneous overflow.
    assign cause_d    = idex_epc_write ? CAUSE_UNDEF : CAUSE_OVF;

    register32bit_normal u_epc (
        .clk   (clk),
        .reset (reset),
        .we    (exc_event),
        .d     (idex_PCVal),
        .q     (EPC)
    );

    register32bit_normal u_cause (
        .clk   (clk),
        .reset (reset),
        .we    (cause_we),
        .d     (cause_d),
        .q     (Cause)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (exc_event) begin
                    state_d = StExcFlush;
                end else if (eret_event) begin
                    state_d = StRetFlush;
                end
            end
            StExcFlush, StRetFlush: begin
                state_d = StDrain;
                cnt_d   = DRAIN_LOAD;
            end
            StDrain: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Outputs depend on registered state (and registered EPC) only.
    always_comb begin
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = 32'd0;
        pipe_hold   = 1'b0;
        exc_busy    = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StExcFlush: begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                flush_exmem = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = EXC_VECTOR;
            end
            StRetFlush: begin
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = EPC + RET_OFFSET;
            end
            StDrain: begin
                pipe_hold = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a lockout-window reference model predicts
// each redirect; a negedge monitor pops and compares.
module tb_exc_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        idex_epc_write, idex_cause_write, ex_overflow, eret_ex;
    logic [31:0] idex_PCVal;
    logic [31:0] EPC, Cause, redirect_pc;
    logic        flush_ifid, flush_idex, flush_exmem, pc_redirect, pipe_hold, exc_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] target;
        logic        fl_exmem;
        logic [31:0] epc;
        logic [31:0] cause;
    } redir_t;

    redir_t exp_q[$];

    // Reference state: stored EPC/Cause and number of upcoming edges ignored.
    logic [31:0] m_epc, m_cause;
    int          m_lock;

    always #5 clk = ~clk;

    exc_ctrl #(
        .EXC_VECTOR   (32'h0000_0080),
        .RET_OFFSET   (32'd2),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .idex_epc_write   (idex_epc_write),
        .idex_cause_write (idex_cause_write),
        .ex_overflow      (ex_overflow),
        .idex_PCVal       (idex_PCVal),
        .eret_ex          (eret_ex),
        .EPC              (EPC),
        .Cause            (Cause),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .flush_exmem      (flush_exmem),
        .pc_redirect      (pc_redirect),
        .redirect_pc      (redirect_pc),
        .pipe_hold        (pipe_hold),
        .exc_busy         (exc_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_epc   = 32'd0;
        m_cause = 32'd0;
        m_lock  = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, predict the response, advance to next edge.
    task automatic drive(input logic ew, input logic cw, input logic ov,
                         input logic [31:0] pc, input logic er);
        redir_t r;
        idex_epc_write   = ew;
        idex_cause_write = cw;
        ex_overflow      = ov;
        idex_PCVal       = pc;
        eret_ex          = er;
        if (m_lock > 0) begin
            m_lock--;
        end else if (ew || ov) begin
            m_epc = pc;
            if (cw || ov) m_cause = ew ? 32'd0 : 32'd1;
            r.target = 32'h80; r.fl_exmem = 1'b1; r.epc = m_epc; r.cause = m_cause;
            exp_q.push_back(r);
            m_lock = 1 + DRAIN;
        end else if (er) begin
            r.target = m_epc + 32'd2; r.fl_exmem = 1'b0; r.epc = m_epc; r.cause = m_cause;
            exp_q.push_back(r);
            m_lock = 1 + DRAIN;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compare each redirect against the scoreboard, measure hold runs.
    int hold_run = 0;
    always @(negedge clk) begin
        redir_t r;
        if (reset) begin
            hold_run = 0;
        end else begin
            if (pc_redirect) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect: got target %h expected none", redirect_pc);
                end else begin
                    r = exp_q.pop_front();
                    check("redirect_pc", redirect_pc, r.target);
                    check("flush_ifid", {31'd0, flush_ifid}, 32'd1);
                    check("flush_idex", {31'd0, flush_idex}, 32'd1);
                    check("flush_exmem", {31'd0, flush_exmem}, {31'd0, r.fl_exmem});
                    check("epc", EPC, r.epc);
                    check("cause", Cause, r.cause);
                    check("busy_redirect", {31'd0, exc_busy}, 32'd1);
                end
            end
            if (pipe_hold) begin
                hold_run++;
            end else if (hold_run != 0) begin
                check("hold_length", hold_run, DRAIN);
                hold_run = 0;
            end
            if (!exc_busy && (flush_ifid || flush_idex || flush_exmem || pc_redirect || pipe_hold)) begin
                checks++;
                errors++;
                $display("FAIL idle_outputs: got active outputs expected all zero in idle");
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_epc"}, EPC, 32'd0);
        check({tag, "_cause"}, Cause, 32'd0);
        check({tag, "_bits"},
              {25'd0, flush_ifid, flush_idex, flush_exmem, pc_redirect, pipe_hold, exc_busy, 1'b0},
              32'd0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idex_epc_write = 1'b0; idex_cause_write = 1'b0; ex_overflow = 1'b0;
        eret_ex = 1'b0; idex_PCVal = 32'h0;
        model_reset();
        #1;
        check_all_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;

        // Undefined instruction at 0x104.
        drive(1'b1, 1'b1, 1'b0, 32'h104, 1'b0);
        idle(3);
        // Overflow at 0x200, wrong-path traps during flush and drain ignored.
        drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 32'h300, 1'b0);
        check("epc_unchanged", EPC, 32'h200);
        // Return from exception.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(3);
        // Undefined and overflow together: undefined wins.
        drive(1'b1, 1'b1, 1'b1, 32'h500, 1'b0);
        idle(3);
        // Exception and eret together: exception wins; cause not rewritten.
        drive(1'b1, 1'b0, 1'b0, 32'h600, 1'b1);
        idle(3);
        // Eret with EPC near the top: return target wraps.
        drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        idle(3);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        idle(3);

        // Reset between edges in the middle of drain.
        drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        idle(1);
        #3;
        check("in_drain_before_reset", {31'd0, pipe_hold}, 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("mid_drain_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        // First event after reset release is taken on the first edge.
        drive(1'b0, 1'b0, 1'b1, 32'h700, 1'b0);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0), $urandom & 32'hFFFF_FFFE,
                  ($urandom_range(0, 4) == 0));
        end
        idle(6);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
